// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for pipe_stage_reg; slave is the stage, master is its environment.
// Statistics counters exist only when PIPE_STAGE_STATS_EN is defined.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready, flush,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
`ifdef PIPE_STAGE_STATS_EN
        ,
        output stall_cnt, bubble_cnt
`endif
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready, flush,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
`ifdef PIPE_STAGE_STATS_EN
        ,
        input  stall_cnt, bubble_cnt
`endif
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, one-entry skid buffer, synchronous flush.
// Optional stall/bubble statistics counters are built when PIPE_STAGE_STATS_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, in_ready=1, out_valid=0
//   ST_FULL  | main entry valid, in_ready=1, out_valid=1
//   ST_SKID  | main and skid valid, in_ready=0, out_valid=1
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 160
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    pipe_stage_reg_if.slave bus
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] main_ctrl_nxt;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_data_nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CTRL_W-1:0] skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data;
    logic [DATA_W-1:0] skid_data_nxt;

    logic out_valid;
    logic in_ready;
    logic accept;
    logic drain;

    // Handshake outputs decode only the state register, so no input reaches them combinationally.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_SKID);
    assign accept    = bus.in_valid & in_ready;
    assign drain     = out_valid & bus.out_ready;

    always_comb begin
        state_nxt     = state;
        main_ctrl_nxt = main_ctrl;
        main_data_nxt = main_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        if (bus.flush) begin
            // Anything accepted this cycle is squashed along with the held entries.
            state_nxt     = ST_EMPTY;
            main_ctrl_nxt = '0;
            main_data_nxt = '0;
            skid_ctrl_nxt = '0;
            skid_data_nxt = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt     = ST_FULL;
                        main_ctrl_nxt = bus.in_ctrl;
                        main_data_nxt = bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        main_ctrl_nxt = bus.in_ctrl;
                        main_data_nxt = bus.in_data;
                    end else if (accept) begin
                        state_nxt     = ST_SKID;
                        skid_ctrl_nxt = bus.in_ctrl;
                        skid_data_nxt = bus.in_data;
                    end else if (drain) begin
                        state_nxt     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_nxt     = ST_FULL;
                        main_ctrl_nxt = skid_ctrl;
                        main_data_nxt = skid_data;
                    end
                end
                default: begin
                    state_nxt     = ST_EMPTY;
                    main_ctrl_nxt = '0;
                    main_data_nxt = '0;
                    skid_ctrl_nxt = '0;
                    skid_data_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            main_ctrl <= main_ctrl_nxt;
            main_data <= main_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
        end
    end

    always_comb begin
        case (state)
            ST_FULL: bus.occupancy = 2'd1;
            ST_SKID: bus.occupancy = 2'd2;
            default: bus.occupancy = 2'd0;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    // Bubbles carry an all-zero control bundle so downstream write enables stay off.
    assign bus.out_ctrl  = out_valid ? main_ctrl : '0;
    assign bus.out_data  = main_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    // Counters see the pre-flush out_valid and survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !bus.out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt  = stall_cnt;
    assign bus.bubble_cnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;
    localparam int CTRL_W = 16;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg_if #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W(4)
`endif
    ) bus ();

    pipe_stage_reg #(
        .CTRL_W(CTRL_W),
        .DATA_W(DATA_W)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic              iv;
        logic              ordy;
        logic              fl;
        logic [CTRL_W-1:0] ctrl;
        logic              e_ov;
        logic              e_ir;
        logic [1:0]        e_occ;
        logic [CTRL_W-1:0] e_ctrl;
    } vec_t;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    vec_t vecs[$];
    ent_t q[$];
    logic [DATA_W-1:0] held;

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [CTRL_W-1:0] ctrl,
                                logic e_ov, logic e_ir, logic [1:0] e_occ, logic [CTRL_W-1:0] e_ctrl);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = ctrl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.in_ctrl   = c;
        bus.in_data   = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        do_reset();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset occupancy", 64'(bus.occupancy), 64'd0);
        chk("reset out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("reset out_data", 64'(bus.out_data), 64'd0);

        // Streaming
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 1, 0, 16'(k), 1, 1, 2'd1, 16'(k)));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 2'd0, 16'h0));
        // Back-pressure
        vecs.push_back(mk(1, 0, 0, 16'h00A1, 1, 1, 2'd1, 16'h00A1));
        vecs.push_back(mk(1, 0, 0, 16'h00A2, 1, 0, 2'd2, 16'h00A1));
        vecs.push_back(mk(1, 0, 0, 16'h00A3, 1, 0, 2'd2, 16'h00A1));
        vecs.push_back(mk(1, 1, 0, 16'h00A3, 1, 1, 2'd1, 16'h00A2));
        vecs.push_back(mk(1, 1, 0, 16'h00A3, 1, 1, 2'd1, 16'h00A3));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 2'd0, 16'h0));
        // Flush from SKID with an incoming instruction
        vecs.push_back(mk(1, 0, 0, 16'h00B1, 1, 1, 2'd1, 16'h00B1));
        vecs.push_back(mk(1, 0, 0, 16'h00B2, 1, 0, 2'd2, 16'h00B1));
        vecs.push_back(mk(1, 0, 1, 16'h00B3, 0, 1, 2'd0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 2'd0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 2'd0, 16'h0));
        // Flush from FULL with accept and drain in the same cycle, then flush on EMPTY
        vecs.push_back(mk(1, 0, 0, 16'h00C1, 1, 1, 2'd1, 16'h00C1));
        vecs.push_back(mk(1, 1, 1, 16'h00C2, 0, 1, 2'd0, 16'h0));
        vecs.push_back(mk(1, 1, 1, 16'h00D1, 0, 1, 2'd0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 2'd0, 16'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, {48'h0, vecs[i].ctrl});
            step();
            chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("vec%0d occupancy", i), 64'(bus.occupancy), 64'(vecs[i].e_occ));
            chk($sformatf("vec%0d out_ctrl", i), 64'(bus.out_ctrl), 64'(vecs[i].e_ctrl));
        end

        // Bubble gating: payload stays visible, control is zeroed
        drive(1, 1, 0, 16'hFFFF, 64'hDEAD_BEEF_0123_4567);
        step();
        chk("gate out_ctrl full", 64'(bus.out_ctrl), 64'hFFFF);
        drive(0, 1, 0, '0, '0);
        step();
        chk("gate out_valid", 64'(bus.out_valid), 64'd0);
        chk("gate out_ctrl bubble", 64'(bus.out_ctrl), 64'h0);
        chk("gate out_data held", 64'(bus.out_data), 64'hDEAD_BEEF_0123_4567);

        // Asynchronous reset while in SKID
        drive(1, 0, 0, 16'h00E1, 64'h11);
        step();
        drive(1, 0, 0, 16'h00E2, 64'h22);
        step();
        chk("pre-rst occupancy", 64'(bus.occupancy), 64'd2);
        drive(0, 0, 0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("async rst in_ready", 64'(bus.in_ready), 64'd1);
        chk("async rst occupancy", 64'(bus.occupancy), 64'd0);
        chk("async rst out_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("async rst out_data", 64'(bus.out_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, '0, '0);
        step();
        chk("post-rst occupancy", 64'(bus.occupancy), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) step();
        chk("bubble_cnt idle", 64'(bus.bubble_cnt), 64'd3);
        drive(1, 0, 0, 16'h0055, 64'h55);
        step();
        drive(0, 0, 0, '0, '0);
        for (int k = 0; k < 20; k++) step();
        chk("stall_cnt saturated", 64'(bus.stall_cnt), 64'd15);
        chk("bubble_cnt during stall", 64'(bus.bubble_cnt), 64'd4);
        drive(0, 0, 1, '0, '0);
        step();
        drive(0, 0, 0, '0, '0);
        chk("stall_cnt after flush", 64'(bus.stall_cnt), 64'd15);
        step();
        chk("bubble_cnt after flush", 64'(bus.bubble_cnt), 64'd5);
        do_reset();
        chk("stall_cnt after rst", 64'(bus.stall_cnt), 64'd0);
        chk("bubble_cnt after rst", 64'(bus.bubble_cnt), 64'd0);
`endif

        // Randomized traffic against a FIFO model of at most two entries
        do_reset();
        q.delete();
        held = '0;
        for (int n = 0; n < 3000; n++) begin
            logic iv, ordy, fl, m_ir, m_ov;
            logic [CTRL_W-1:0] c;
            logic [DATA_W-1:0] d;
            ent_t e;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            c    = CTRL_W'($urandom);
            d    = {$urandom, $urandom};
            drive(iv, ordy, fl, c, d);
            m_ir = (q.size() < 2);
            m_ov = (q.size() != 0);
            if (m_ov && ordy) void'(q.pop_front());
            if (fl) q.delete();
            else if (iv && m_ir) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
            if (fl) held = '0;
            else if (q.size() != 0) held = q[0].d;
            step();
            chk($sformatf("rnd%0d out_valid", n), 64'(bus.out_valid), 64'(q.size() != 0));
            chk($sformatf("rnd%0d in_ready", n), 64'(bus.in_ready), 64'(q.size() < 2));
            chk($sformatf("rnd%0d occupancy", n), 64'(bus.occupancy), 64'(q.size()));
            chk($sformatf("rnd%0d out_ctrl", n), 64'(bus.out_ctrl), (q.size() != 0) ? 64'(q[0].c) : 64'd0);
            chk($sformatf("rnd%0d out_data", n), 64'(bus.out_data), 64'(held));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
